// File: rtl/mem_burst_responder_pkg.sv
// mem_defs: shared FSM states, block geometry and address-field constants for the refill path
package mem_defs;
  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ADDR_W  = 11;
  localparam int DEF_OFF_W   = 3;
  localparam int DEF_LATENCY = 2;
  localparam int BLK_WORDS   = 1 << DEF_OFF_W;
  localparam int LINE_W      = 2;
  localparam int LINE_LSB    = DEF_OFF_W;
  localparam int TAG_LSB     = DEF_OFF_W + LINE_W;
  localparam int TAG_W       = DEF_ADDR_W - TAG_LSB;
endpackage

// File: rtl/mem_burst_responder_burst_counter.sv
// burst_counter: modulo-BLK_WORDS beat offset counter with load, enable and end-of-burst flag
module burst_counter
  import mem_defs::*;
#(
  parameter int OFF_W = DEF_OFF_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [OFF_W-1:0] start,
  output logic [OFF_W-1:0] idx,
  output logic             last
);
  logic [OFF_W-1:0] idx_q, idx_d, start_q, start_d;
  always_comb begin
    idx_d   = load ? start : en ? OFF_W'(idx_q + 1'b1) : idx_q;
    start_d = load ? start : start_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      idx_q   <= '0;
      start_q <= '0;
    end else begin
      idx_q   <= idx_d;
      start_q <= start_d;
    end
  assign idx  = idx_q;
  assign last = OFF_W'(idx_q + 1'b1) == start_q;
endmodule

// File: rtl/mem_burst_responder.sv
// mem_burst_responder: byte-write / block-burst-read memory responder (CRIT_WORD_FIRST_EN: wrap burst from requested word)
module mem_burst_responder
  import mem_defs::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int OFF_W   = DEF_OFF_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              wr_done,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [OFF_W-1:0]  rsp_idx,
  output logic              rsp_last
);
  localparam int CNT_W = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY > 0 ? LATENCY - 1 : 0);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-OFF_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic valid_q, valid_d, wr_done_q, wr_done_d;
  logic accept, rd_acc, hs, fetch, last;
  logic [OFF_W-1:0] idx, start, fetch_off;
  assign req_ready = state_q == IDLE;
  assign accept    = req_valid & req_ready;
  assign rd_acc    = accept & ~req_we;
  assign hs        = valid_q & rsp_ready;
  assign fetch     = state_q == BURST && (!valid_q || (rsp_ready && !last));
  assign fetch_off = valid_q ? OFF_W'(idx + 1'b1) : idx;
`ifdef CRIT_WORD_FIRST_EN
  assign start = req_addr[OFF_W-1:0];
`else
  assign start = '0;
`endif
  burst_counter #(.OFF_W(OFF_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (rd_acc),
    .en    (hs),
    .start (start),
    .idx   (idx),
    .last  (last)
  );
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    data_d    = data_q;
    valid_d   = valid_q;
    wr_done_d = accept & req_we;
    if (rd_acc) begin
      base_d  = req_addr[ADDR_W-1:OFF_W];
      cnt_d   = CNT_INIT;
      state_d = LATENCY == 0 ? BURST : WAIT;
    end
    if (state_q == WAIT) begin
      cnt_d   = cnt_q - 1'b1;
      state_d = cnt_q == '0 ? BURST : WAIT;
    end
    if (fetch) begin
      data_d  = mem[{base_q, fetch_off}];
      valid_d = 1'b1;
    end
    if (hs && last) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      base_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      wr_done_q <= wr_done_d;
    end
  always_ff @(posedge clk)
    if (accept && req_we) mem[req_addr] <= req_wdata;
  assign wr_done   = wr_done_q;
  assign rsp_valid = valid_q;
  assign rsp_data  = data_q;
  assign rsp_idx   = idx;
  assign rsp_last  = valid_q & last;
endmodule

// File: tb/tb_mem_burst_responder.sv
// tb_mem_burst_responder: directed checks of writes, bursts, stalls, reset abort, top block, pending request, zero latency
module tb_mem_burst_responder;
  logic clk = 0, reset = 1, req_valid = 0, req_we = 0, rsp_ready = 1;
  logic [10:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic req_ready, wr_done, rsp_valid, rsp_last, req_ready0, wr_done0, rsp_valid0, rsp_last0;
  logic [7:0] rsp_data, rsp_data0;
  logic [2:0] rsp_idx, rsp_idx0;
  logic [7:0] model [2048];
  int pass_cnt = 0, fail_cnt = 0, total = 0;
`ifdef CRIT_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif
  always #5 clk = ~clk;
  mem_burst_responder dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .wr_done(wr_done), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_idx(rsp_idx), .rsp_last(rsp_last)
  );
  mem_burst_responder #(.LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .wr_done(wr_done0), .rsp_valid(rsp_valid0),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data0), .rsp_idx(rsp_idx0), .rsp_last(rsp_last0)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [2:0] start_of(input logic [10:0] a);
    return CWF ? a[2:0] : 3'd0;
  endfunction
  task automatic wr(input logic [10:0] a, input logic [7:0] d);
    req_valid = 1; req_we = 1; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 0; req_we = 0; model[a] = d;
    chk("wr_done", wr_done, 1);
  endtask
  task automatic get_burst(input logic [10:0] a, input int stall_at, input int reset_at);
    logic [2:0] i;
    for (int b = 0; b < 8; b++) begin
      i = start_of(a) + 3'(b);
      chk("beat_valid", rsp_valid, 1);
      chk("beat_idx", rsp_idx, i);
      chk("beat_data", rsp_data, model[{a[10:3], i}]);
      chk("beat_last", rsp_last, b == 7);
      if (b == 0) chk("busy_ready", req_ready, 0);
      if (b == reset_at) begin
        reset = 1; #1;
        chk("rst_valid_drop", rsp_valid, 0);
        @(posedge clk); #1;
        reset = 0; #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_idx", rsp_idx, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_last", rsp_last, 0);
        chk("rst_wr_done", wr_done, 0);
        return;
      end
      if (b == stall_at) begin
        rsp_ready = 0;
        repeat (3) begin
          @(posedge clk); #1;
          chk("stall_valid", rsp_valid, 1);
          chk("stall_idx", rsp_idx, i);
          chk("stall_data", rsp_data, model[{a[10:3], i}]);
          chk("stall_last", rsp_last, 0);
        end
        rsp_ready = 1;
      end
      @(posedge clk); #1;
    end
    chk("end_valid", rsp_valid, 0);
    chk("end_ready", req_ready, 1);
  endtask
  task automatic wait_first();
    int n = 0;
    chk("acc_no_valid", rsp_valid, 0);
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 3);
  endtask
  task automatic rd(input logic [10:0] a, input int stall_at, input int reset_at);
    req_valid = 1; req_we = 0; req_addr = a;
    chk("acc_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0;
    wait_first();
    get_burst(a, stall_at, reset_at);
  endtask
  initial begin
    int seen;
    logic [2:0] i;
    repeat (2) @(posedge clk);
    #1; reset = 0; #1;
    chk("reset_ready", req_ready, 1);
    chk("reset_valid", rsp_valid, 0);
    chk("reset_last", rsp_last, 0);
    chk("reset_wr_done", wr_done, 0);
    chk("reset_data", rsp_data, 0);
    chk("reset_idx", rsp_idx, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) wr(11'h0A8 + 11'(k), 8'h10 + 8'(k));
    for (int k = 0; k < 8; k++) wr(11'h120 + 11'(k), 8'h20 + 8'(k));
    for (int k = 0; k < 8; k++) wr(11'h7F8 + 11'(k), 8'hE0 + 8'(k));
    wr(11'h000, 8'h99);
    @(posedge clk); #1;
    chk("wr_done_idle", wr_done, 0);
    // 1: basic burst, latency 2
    rd(11'h0AB, -1, -1);
    // zero-latency instance sees the first beat one cycle after accept
    req_valid = 1; req_we = 0; req_addr = 11'h0AB;
    @(posedge clk); #1;
    req_valid = 0;
    chk("lat0_first_idle", rsp_valid0, 0);
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk); #1;
      i = start_of(11'h0AB) + 3'(n - 1);
      if (n <= 8) begin
        chk("lat0_valid", rsp_valid0, 1);
        chk("lat0_idx", rsp_idx0, i);
        chk("lat0_data", rsp_data0, model[{8'h15, i}]);
        chk("lat0_last", rsp_last0, n == 8);
      end else chk("lat0_end", rsp_valid0, 0);
    end
    seen = 0;
    while (!(req_ready && !rsp_valid) && seen < 20) begin
      @(posedge clk); #1;
      seen++;
    end
    chk("drain_ready", req_ready, 1);
    // 2: write then read back the block
    wr(11'h123, 8'h5A);
    @(posedge clk); #1;
    chk("wr_done_pulse_end", wr_done, 0);
    chk("model_5a", model[11'h123], 8'h5A);
    rd(11'h120, -1, -1);
    // 3: backpressure at beat 4
    rd(11'h0A8, 4, -1);
    // 4: reset during beat 5, then re-read
    rd(11'h0A8, -1, 5);
    @(posedge clk); #1;
    rd(11'h0A8, -1, -1);
    // 5: top block stays inside 0x7F8..0x7FF
    rd(11'h7FC, -1, -1);
    // 6: second request held during a burst is accepted exactly once
    req_valid = 1; req_we = 0; req_addr = 11'h0A8;
    @(posedge clk); #1;
    req_addr = 11'h7F8;
    wait_first();
    get_burst(11'h0A8, -1, -1);
    @(posedge clk); #1;
    req_valid = 0;
    chk("pend_accepted", req_ready, 0);
    wait_first();
    get_burst(11'h7F8, -1, -1);
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    chk("no_extra_burst", seen, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
